// File: rtl/seg_scan_if.sv
// Bus between the value producer and the 7-segment scan controller.
// The master produces display values; the slave (the scan controller) drives the pins.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  lzb_en;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  frame_done;

  modport master (
    output load,
    output value,
    output lzb_en,
    input  an,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  load,
    input  value,
    input  lzb_en,
    output an,
    output seg,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// One digit is lit at a time, separated by an all-off blanking gap. New values are
// double-buffered and swapped in only at frame wrap so a multi-digit update never tears.
// All pin outputs are registered, lagging the internal state by one clock.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic         clk,
  input logic         rst_n,
  seg_scan_if.slave   bus
);

  localparam int unsigned CntMax = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ValW   = 4 * DIGITS;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

  localparam logic [0:0] StBlank = 1'b0;
  localparam logic [0:0] StShow  = 1'b1;

  localparam logic [6:0] SegOff = 7'b1111111;

  // Active-low {a,b,c,d,e,f,g}; non-BCD nibbles render blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0001100;
      default: pat = SegOff;
    endcase
    return pat;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [ValW-1:0]  active_q, active_d;
  logic [ValW-1:0]  pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic             wrap_q;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_done_q;

  logic             blank_done;
  logic             show_done;
  logic             wrap;
  logic [3:0]       cur_nibble;
  logic [DIGITS-1:0] suppress;

  assign blank_done = (state_q == StBlank) && (cnt_q == BlankLast);
  assign show_done  = (state_q == StShow) && (cnt_q == ShowLast);
  assign wrap       = show_done && (idx_q == IdxLast);
  assign cur_nibble = active_q[{idx_q, 2'b00} +: 4];

  // Scan sequencing: BLANK -> SHOW per digit, index advances at the end of each SHOW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    if (blank_done) begin
      state_d = StShow;
      cnt_d   = '0;
    end else if (show_done) begin
      state_d = StBlank;
      cnt_d   = '0;
      idx_d   = wrap ? '0 : idx_q + IdxW'(1);
    end
  end

  // Double buffer: a load on the wrap cycle bypasses straight into active,
  // otherwise loads land in pending (last one wins) and swap at the next wrap.
  always_comb begin
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (wrap) begin
      if (bus.load) begin
        active_d        = bus.value;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        active_d        = pending_q;
        pending_valid_d = 1'b0;
      end
    end else if (bus.load) begin
      pending_d       = bus.value;
      pending_valid_d = 1'b1;
    end
  end

  // Leading-zero suppression: digit i>0 is dark when it and every higher nibble are zero.
  always_comb begin
    logic hi_zero;
    suppress = '0;
    hi_zero  = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      hi_zero     = hi_zero && (active_q[4*i +: 4] == 4'd0);
      suppress[i] = bus.lzb_en && hi_zero;
    end
  end

  // Pin values for the next cycle, derived from the current state.
  always_comb begin
    an_d  = '1;
    seg_d = SegOff;
    if (state_q == StShow && !suppress[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg_decode(cur_nibble);
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Display value buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end

  // Registered outputs; frame_done is delayed one extra cycle to line up with the
  // first blank output cycle of digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q         <= '1;
      seg_q        <= SegOff;
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      wrap_q       <= wrap;
      frame_done_q <= wrap_q;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. It holds a BCD display value and selects one digit at a time through active-low anode lines, driving active-low segment patterns with the team's standard 0–9 encoding. A blanking gap between digits prevents ghosting. New values are applied only at frame boundaries, so a multi-digit update never tears. It sits between the system logic that produces display values and the board's anode/segment pins.

## Interface
- DIGITS, 4: number of multiplexed digits (1–8); digit 0 is least significant.
- DIV, 50000: clock cycles each digit is shown (≥1).
- BLANK_CYCLES, 16: clock cycles all anodes are off before each digit (≥1).
- clk  input  1  system clock; one clock domain only.
- rst_n  input  1  reset, asynchronous and active-low.
- load  input  1  single-cycle strobe; samples `value` on this edge.
- value  input  4*DIGITS  packed BCD; nibble i is digit i.
- lzb_en  input  1  leading-zero blanking enable.
- an  output  DIGITS  active-low anode selects; at most one bit low.
- seg  output  7  active-low segments {a,b,c,d,e,f,g}.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

## Operation
- Registers:
  - `active` (4*DIGITS): the value being displayed.
  - `pending` (4*DIGITS) with `pending_valid`: the next value to display.
  - `idx`: digit index, 0..DIGITS-1.
  - `cnt`: width $clog2 of max(DIV, BLANK_CYCLES).
  - `state`: BLANK or SHOW.
- BLANK state:
  - an = all ones; seg = 7'b1111111.
  - After BLANK_CYCLES cycles, go to SHOW and reset cnt.
- SHOW state:
  - an[idx] = 0 unless the digit is suppressed; seg = decode(active nibble idx).
  - After DIV cycles, go to BLANK and reset cnt.
  - If idx = DIGITS-1: wrap idx to 0 and pulse frame_done. Otherwise increment idx.
- Frame swap on wrap:
  - If pending_valid, copy pending into active and clear pending_valid.
  - If load is asserted on the wrap cycle, `value` goes directly into active (bypass) and pending_valid is cleared.
- load at any other time writes pending and sets pending_valid. Several loads within one frame: the last one wins.
- Decode table (active-low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0001100
  - Nibbles 10–15 give 1111111 (blank) with the anode still asserted.
- Leading-zero blanking:
  - When lzb_en = 1, digit i > 0 is suppressed if nibble i and every more significant nibble in `active` are 0.
  - A suppressed digit keeps an high and seg = 1111111 for its SHOW window. Its timing slot is unchanged.
  - Digit 0 is never suppressed.
  - lzb_en is sampled combinationally against `active`; it may change at any time.

## Timing
- Reset (asynchronous, immediate):
  - an = all ones, seg = 1111111, frame_done = 0.
  - active = 0, pending_valid = 0, idx = 0, state = BLANK, cnt = 0.
- After rst_n deasserts, the first edge starts BLANK for digit 0.
- All outputs are registered: they change on the clk edge after the state/cnt transition, so there is no combinational path from inputs to pins.
- Digit period = BLANK_CYCLES + DIV. Frame period = DIGITS × (BLANK_CYCLES + DIV).
- frame_done is high for exactly one cycle: the first BLANK cycle of digit 0 in the next frame.
- A swapped value is visible from the first SHOW cycle of digit 0 in the new frame.
- Reset asserted mid-SHOW forces all outputs blank immediately, without waiting for clk. Any pending value is discarded.

## Test plan
- Reset, DIGITS=4, DIV=4, BLANK_CYCLES=2:
  - During reset, an=1111 and seg=1111111.
  - After release, 2 blank cycles, then an=1110 and seg=0000001 for 4 cycles.
  - Then 2 blank cycles, then an=1101.
- Same parameters, load value=16'h1234 mid-frame:
  - The current frame still shows 0000.
  - The next frame shows digit0 = 1001100 (4), digit1 = 0000110, digit2 = 0010010, digit3 = 1001111.
  - frame_done pulses every 24 cycles.
- lzb_en=1 with active=16'h0050:
  - Digits 3 and 2 keep an=1111 during their windows.
  - Digit 1 shows 0100100; digit 0 shows 0000001.
- value=16'h00A7 loaded:
  - Digit 1 shows an=1101, seg=1111111.
  - Digit 0 shows 0001111.
- Two loads in one frame (16'h1111, then 16'h2222) → the next frame shows only 2222. A load on the wrap cycle → the new value is shown in the immediately following frame.
- rst_n pulled low during a SHOW window → an and seg go to all ones in the same cycle, and pending is lost. After release, the scan restarts at digit 0 showing 0.
